fifo_sync_flags: RTL and testbench

//  Parametrised synchronous FIFO, successor to the delay-line sample buffer.

---
 rtl/fifo_sync_flags.sv | 142 ++++++++++++++
 tb/tb_fifo_sync_flags.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy level, programmable almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through; the default is a registered-read FIFO.
module fifo_sync_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 10,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L     = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] AE_L     = LVL_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             rd_ok, wr_ok, mem_rd;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (level_q == DEPTH_L);
    assign wr_ok = wr_en & (~full | rd_ok);

`ifdef FIFO_FWFT_EN
    logic [LVL_W-1:0] mem_cnt_q, mem_cnt_d;

    // Output register is part of the capacity; refill it whenever it is free or being consumed.
    assign empty  = ~dout_valid_q;
    assign rd_ok  = rd_en & dout_valid_q;
    assign mem_rd = (mem_cnt_q != '0) & (~dout_valid_q | rd_ok);

    always_comb begin
        mem_cnt_d    = mem_cnt_q;
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        if (wr_ok && !mem_rd)
            mem_cnt_d = mem_cnt_q + 1'b1;
        else if (mem_rd && !wr_ok)
            mem_cnt_d = mem_cnt_q - 1'b1;
        if (mem_rd) begin
            dout_valid_d = 1'b1;
            dout_d       = mem_q[rd_ptr_q];
        end else if (rd_ok) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_cnt_q <= '0;
        else
            mem_cnt_q <= mem_cnt_d;
    end
`else
    assign empty  = (level_q == '0);
    assign rd_ok  = rd_en & ~empty;
    assign mem_rd = rd_ok;

    always_comb begin
        dout_valid_d = rd_ok;
        dout_d       = dout_q;
        if (rd_ok)
            dout_d = mem_q[rd_ptr_q];
    end
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok)
            wr_ptr_d = ptr_inc(wr_ptr_q);
        if (mem_rd)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        if (wr_ok && !rd_ok)
            level_d = level_q + 1'b1;
        else if (rd_ok && !wr_ok)
            level_d = level_q - 1'b1;
        // A same-cycle rejection wins over the clear.
        ovf_d = (ovf_q & ~err_clr) | (wr_en & ~wr_ok);
        udf_d = (udf_q & ~err_clr) | (rd_en & ~rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out     = dout_q;
    assign dout_valid   = dout_valid_q;
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags at WIDTH=8, DEPTH=10, AF=8, AE=2.
module tb_fifo_sync_flags;
    localparam int WIDTH = 8;
    localparam int DEPTH = 10;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en, rd_en, err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             dout_valid, empty, full, almost_empty, almost_full;
    logic             overflow, underflow;
    logic [LVL_W-1:0] level;

    int checks = 0;
    int errors = 0;

    fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(8), .AE_THRESH(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .dout_valid(dout_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic c);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        err_clr = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp_d, rd_data;
        logic             w, r, rok, wok;
        int               wrs, ncyc;

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_dvalid", dout_valid, 0);
        check("rst_dout", data_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        rst_n = 1'b1;

`ifdef FIFO_FWFT_EN
        cyc(1'b1, 1'b0, 8'h5A, 1'b0);
        check("fwft_dv_edge1", dout_valid, 0);
        check("fwft_lvl_edge1", level, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("fwft_dv_edge2", dout_valid, 1);
        check("fwft_dout", data_out, 8'h5A);
        check("fwft_empty", empty, 0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        check("fwft_pop_dv", dout_valid, 0);
        check("fwft_pop_lvl", level, 0);
        check("fwft_pop_empty", empty, 1);
`else
        for (int k = 1; k <= DEPTH; k++) begin
            cyc(1'b1, 1'b0, WIDTH'(k), 1'b0);
            check($sformatf("fill_lvl_%0d", k), level, k);
            check($sformatf("fill_full_%0d", k), full, k == DEPTH);
            check($sformatf("fill_afull_%0d", k), almost_full, k >= 8);
            check($sformatf("fill_aempty_%0d", k), almost_empty, k <= 2);
            check($sformatf("fill_empty_%0d", k), empty, 0);
        end

        cyc(1'b1, 1'b0, 8'hAA, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_lvl", level, DEPTH);
        check("ovf_dv", dout_valid, 0);

        cyc(1'b1, 1'b1, 8'hBB, 1'b0);
        check("fullrw_dout", data_out, 1);
        check("fullrw_dv", dout_valid, 1);
        check("fullrw_lvl", level, DEPTH);
        check("fullrw_ovf_sticky", overflow, 1);

        for (int i = 1; i <= DEPTH; i++) begin
            exp_d = (i == DEPTH) ? 8'hBB : WIDTH'(i + 1);
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            check($sformatf("drain_dout_%0d", i), data_out, exp_d);
            check($sformatf("drain_dv_%0d", i), dout_valid, 1);
            check($sformatf("drain_lvl_%0d", i), level, DEPTH - i);
        end
        check("drain_empty", empty, 1);

        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_dv", dout_valid, 0);
        check("idle_hold", data_out, 8'hBB);

        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        check("udf_set", underflow, 1);
        check("udf_dv", dout_valid, 0);
        check("udf_lvl", level, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_udf", underflow, 0);
        check("clr_ovf", overflow, 0);

        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        check("clr_vs_err", underflow, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_again", underflow, 0);

        cyc(1'b1, 1'b1, 8'h33, 1'b0);
        check("emptyrw_udf", underflow, 1);
        check("emptyrw_lvl", level, 1);
        check("emptyrw_dv", dout_valid, 0);
        check("emptyrw_empty", empty, 0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        check("emptyrw_dout", data_out, 8'h33);
        check("emptyrw_dv2", dout_valid, 1);
        check("emptyrw_udf_clr", underflow, 0);

        wrs  = 0;
        ncyc = 0;
        while (wrs < 25 * DEPTH && ncyc < 5000) begin
            w       = 1'($urandom_range(0, 1));
            r       = 1'($urandom_range(0, 1));
            exp_d   = 8'($urandom);
            rok     = r && (q.size() != 0);
            wok     = w && (q.size() < DEPTH || rok);
            rd_data = '0;
            if (rok) rd_data = q.pop_front();
            if (wok) begin
                q.push_back(exp_d);
                wrs++;
            end
            cyc(w, r, exp_d, 1'b0);
            ncyc++;
            check("rnd_dv", dout_valid, rok);
            if (rok) check("rnd_dout", data_out, rd_data);
            check("rnd_lvl", level, q.size());
            check("rnd_full", full, q.size() == DEPTH);
        end
        check("rnd_budget", wrs >= 25 * DEPTH, 1);

        while (q.size() != 0) begin
            rd_data = q.pop_front();
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            check("rnd_drain", data_out, rd_data);
        end
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        check("pre_rst_udf", underflow, 1);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, WIDTH'(8'h60 + k), 1'b0);
        check("pre_rst_lvl", level, 6);

        #3 rst_n = 1'b0;
        #1;
        check("mrst_lvl", level, 0);
        check("mrst_empty", empty, 1);
        check("mrst_aempty", almost_empty, 1);
        check("mrst_afull", almost_full, 0);
        check("mrst_full", full, 0);
        check("mrst_udf", underflow, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_dv", dout_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_rst_udf", underflow, 1);
        check("post_rst_dv", dout_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
